alu_nibble_sequencer: RTL and testbench

//  Multi-cycle controller that performs WIDTH-bit ALU ops by streaming operands LSB-nibble-first through one ALU4Bit slice.

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_nibble_sequencer_alu4.sv | 39 +++
 rtl/alu_nibble_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer.
// Contents: op codes, sequencer FSM states, and a helper that flags subtract-type ops.
// Subtract-type ops (SUB, SLT) start the carry chain at 1 so the slice computes A + ~B + 1.
package alu_seq_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_is_sub(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_nibble_sequencer_alu4.sv
// ALU4Bit: combinational 4-bit ALU slice (AND / OR / ADD, B optionally inverted).
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller sequences nibbles through it.
// Ports:
//   a_i, b_i [3:0]  operand nibbles
//   op_i     [2:0]  op code; bit 2 inverts B, bits 1:0 select AND/OR/ADD/XOR
//   cin_i           carry in (used by the adder only)
//   res_o    [3:0]  result nibble
//   cout_o          adder carry out; 0 for logic ops
module ALU4Bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [2:0] op_i,
  input  logic       cin_i,
  output logic [3:0] res_o,
  output logic       cout_o
);

  logic [3:0] b_eff;
  logic [4:0] sum;

  always_comb begin
    // SUB is A + ~B + 1: inversion here, the +1 comes in through cin_i.
    b_eff  = op_i[2] ? ~b_i : b_i;
    sum    = {1'b0, a_i} + {1'b0, b_eff} + {4'b0000, cin_i};
    res_o  = 4'h0;
    cout_o = 1'b0;
    case (op_i[1:0])
      2'b00:   res_o = a_i & b_eff;
      2'b01:   res_o = a_i | b_eff;
      2'b10: begin
        res_o  = sum[3:0];
        cout_o = sum[4];
      end
      default: res_o = a_i ^ b_eff;
    endcase
  end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: performs WIDTH-bit ALU ops by streaming operands LSB nibble first through one ALU4Bit.
// Latency: out_valid rises NIBBLES cycles after the accept edge; min issue interval NIBBLES+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, then returns to IDLE.
// Optional feature macro: ALU_SEQ_OVERFLOW_EN (adds out_ovf and a signed-correct SLT).
// Ports:
//   clk, rst                     clock, async active-high reset
//   in_valid/in_ready            request handshake; in_op, in_a, in_b latched on accept
//   out_valid/out_ready          result handshake; out_result, out_cout (and out_ovf) stable while waiting
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout
`ifdef ALU_SEQ_OVERFLOW_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("alu_nibble_sequencer: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic             ovf_q, ovf_d;
  logic             ovf_calc;
`endif

  logic [2:0]       slice_op;
  logic [3:0]       slice_res;
  logic             slice_cout;
  logic [WIDTH-1:0] res_shift;
  logic             lt;

  // The slice has no SLT; a compare is a subtract whose sign is inspected afterwards.
  assign slice_op = (op_q == OP_SLT) ? OP_SUB : op_q;

  ALU4Bit u_alu4 (
    .a_i   (a_sh_q[3:0]),
    .b_i   (b_sh_q[3:0]),
    .op_i  (slice_op),
    .cin_i (carry_q),
    .res_o (slice_res),
    .cout_o(slice_cout)
  );

  // New nibble enters at the MSB end so after NIBBLES steps the word is in order.
  generate
    if (WIDTH == 4) begin : g_res_one
      assign res_shift = slice_res;
    end else begin : g_res_many
      assign res_shift = {slice_res, res_q[WIDTH-1:4]};
    end
  endgenerate

  // On the last RUN cycle a_sh_q[3]/b_sh_q[3] are the operand sign bits.
`ifdef ALU_SEQ_OVERFLOW_EN
  assign ovf_calc = (a_sh_q[3] == (b_sh_q[3] ^ op_is_sub(op_q))) && (slice_res[3] != a_sh_q[3]);
  assign lt       = slice_res[3] ^ ovf_calc;
`else
  // Sign of A-B only: gives the wrong answer when the subtraction overflows.
  assign lt       = slice_res[3];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    op_d    = op_q;
    carry_d = carry_q;
    res_d   = res_q;
    cout_d  = cout_q;
`ifdef ALU_SEQ_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          cnt_d   = '0;
          a_sh_d  = in_a;
          b_sh_d  = in_b;
          op_d    = in_op;
          carry_d = op_is_sub(in_op);
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        carry_d = slice_cout;
        res_d   = res_shift;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          cout_d  = 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
          case (op_q)
            OP_ADD, OP_SUB: begin
              cout_d = slice_cout;
`ifdef ALU_SEQ_OVERFLOW_EN
              ovf_d  = ovf_calc;
`endif
            end
            OP_SLT: begin
              res_d = WIDTH'(lt);
`ifdef ALU_SEQ_OVERFLOW_EN
              ovf_d = ovf_calc;
`endif
            end
            default: ;
          endcase
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      op_q    <= OP_AND;
      carry_q <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
`ifdef ALU_SEQ_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = res_q;
  assign out_cout   = cout_q;
`ifdef ALU_SEQ_OVERFLOW_EN
  assign out_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer (WIDTH=16): directed vector table plus backpressure and mid-RUN reset sequences.
// Inputs driven and outputs sampled on the falling clock edge.
// Build with or without ALU_SEQ_OVERFLOW_EN; SLT/overflow expectations follow the macro.
module tb_alu_nibble_sequencer;
  import alu_seq_pkg::*;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = 3'b000;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic             out_ovf;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_cout  (out_cout)
`ifdef ALU_SEQ_OVERFLOW_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  typedef struct {
    string            name;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for in_ready, presents one request for a single cycle.
  // Returns at the falling edge right after the accept edge.
  task automatic issue(input string name, input logic [2:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    issue(v.name, v.op, v.a, v.b);
    wait_valid(lat);
    check({v.name, " latency"}, 32'(lat), 32'(NIBBLES));
    check({v.name, " result"}, 32'(out_result), 32'(v.res));
    check({v.name, " cout"}, 32'(out_cout), 32'(v.cout));
`ifdef ALU_SEQ_OVERFLOW_EN
    check({v.name, " ovf"}, 32'(out_ovf), 32'(v.ovf));
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({v.name, " valid drop"}, 32'(out_valid), 32'd0);
    check({v.name, " ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t vecs[11];
    vec_t v;
    int   lat;
    int   vcount;

    vecs[0]  = '{"add_1234_0fff", OP_ADD, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0};
    vecs[1]  = '{"add_ffff_0001", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{"and_f0f0_3c3c", OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0};
    vecs[3]  = '{"sub_5_7",       OP_SUB, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[4]  = '{"sub_7_5",       OP_SUB, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0};
    vecs[5]  = '{"or_00f0_0f0f",  OP_OR,  16'h00F0, 16'h0F0F, 16'h0FFF, 1'b0, 1'b0};
    vecs[6]  = '{"add_7fff_0001", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[7]  = '{"sub_1000_0001", OP_SUB, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0};
    vecs[8]  = '{"slt_1_2",       OP_SLT, 16'h0001, 16'h0002, 16'h0001, 1'b0, 1'b0};
    vecs[9]  = '{"slt_5_3",       OP_SLT, 16'h0005, 16'h0003, 16'h0000, 1'b0, 1'b0};
`ifdef ALU_SEQ_OVERFLOW_EN
    vecs[10] = '{"slt_8000_0001", OP_SLT, 16'h8000, 16'h0001, 16'h0001, 1'b0, 1'b1};
`else
    vecs[10] = '{"slt_8000_0001", OP_SLT, 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0};
`endif

    // Reset state, both while held and just after release.
    repeat (3) @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_result", 32'(out_result), 32'd0);
    check("rst out_cout", 32'(out_cout), 32'd0);
`ifdef ALU_SEQ_OVERFLOW_EN
    check("rst out_ovf", 32'(out_ovf), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("post-rst out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Consumer stalls 5 cycles in DONE while new requests are offered.
    issue("bp", OP_ADD, 16'h1234, 16'h0FFF);
    wait_valid(lat);
    check("bp latency", 32'(lat), 32'(NIBBLES));
    for (int i = 0; i < 5; i++) begin
      check("bp hold valid", 32'(out_valid), 32'd1);
      check("bp hold result", 32'(out_result), 32'h2233);
      check("bp in_ready low", 32'(in_ready), 32'd0);
      in_valid = (i % 2 == 0);
      in_op    = OP_ADD;
      in_a     = 16'hFFFF;
      in_b     = 16'hFFFF;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) vcount++;
      @(negedge clk);
    end
    check("bp single delivery", 32'(vcount), 32'd0);
    check("bp result retained", 32'(out_result), 32'h2233);

    // Reset pulse two cycles into RUN aborts the op.
    issue("rst_mid", OP_ADD, 16'h00FF, 16'h0001);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid out_valid", 32'(out_valid), 32'd0);
    check("rst_mid out_result", 32'(out_result), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid in_ready", 32'(in_ready), 32'd1);
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) vcount++;
      @(negedge clk);
    end
    check("rst_mid no result", 32'(vcount), 32'd0);
    v = '{"add_after_rst", OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0};
    run_vec(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
